// File: rtl/axis_ifm_rx.sv
// axis_ifm_rx: AXI-Stream slave that receives one IFM frame (3 parameter words
// followed by an IMG_H x IMG_W 8-bit image). Rows go into a 5-slot ring buffer
// and are replayed as sliding 5-row windows, 3 pixels per row per cycle,
// advancing 3 image rows per pass.
module axis_ifm_rx #(
  parameter int IMG_W     = 50,
  parameter int IMG_H     = 50,
  parameter int ROW_WORDS = 13,
  parameter int PE_DRAIN  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_axis_tdata,
  input  logic [3:0]  s_axis_tkeep,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [79:0] o_params,
  output logic        o_params_valid,
  output logic [23:0] o_pe_1_row,
  output logic [23:0] o_pe_2_row,
  output logic [23:0] o_pe_3_row,
  output logic [23:0] o_pe_4_row,
  output logic [23:0] o_pe_5_row,
  output logic        o_pe_valid,
  output logic        o_img_row_done,
  output logic        o_send_flg,
  output logic        o_err
);

  localparam int ROW_BITS  = ROW_WORDS * 32;
  localparam int NUM_PASS  = (IMG_H - 2) / 3;
  localparam int LAST_BEAT = 3 + IMG_H * ROW_WORDS - 1;
  localparam int BW        = $clog2(LAST_BEAT + 1);
  localparam int PW        = $clog2(NUM_PASS + 1);
  localparam int CW        = $clog2(IMG_W - 2);
  localparam int WW        = $clog2(ROW_WORDS);
  localparam int DW        = $clog2(PE_DRAIN + 1);

  localparam logic [BW-1:0] LAST_BEAT_V = BW'(LAST_BEAT);
  localparam logic [PW-1:0] LAST_PASS_V = PW'(NUM_PASS - 1);
  localparam logic [CW-1:0] LAST_COL_V  = CW'(IMG_W - 3);
  localparam logic [WW-1:0] LAST_WORD_V = WW'(ROW_WORDS - 1);
  localparam logic [DW-1:0] LAST_DRN_V  = DW'(PE_DRAIN - 1);

  typedef enum logic [2:0] {
    S_PARAM,
    S_FILL,
    S_EMIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t              state;
  logic [BW-1:0]       beat_cnt;
  logic [31:0]         param_w0;
  logic [31:0]         param_w1;
  logic [WW-1:0]       wr_word;
  logic [2:0]          wr_slot;
  logic [2:0]          rows_left;
  logic [2:0]          base_slot;
  logic [CW-1:0]       col;
  logic [PW-1:0]       pass_cnt;
  logic [DW-1:0]       drain_cnt;
  logic [ROW_BITS-1:0] ring [5];
  logic [23:0]         pe_q [5];
  logic [2:0]          rd_slot [5];
  logic                accept;
  logic                unused_tkeep;

  assign accept       = s_axis_tvalid && s_axis_tready;
  assign unused_tkeep = ^s_axis_tkeep;

  assign o_pe_1_row = pe_q[0];
  assign o_pe_2_row = pe_q[1];
  assign o_pe_3_row = pe_q[2];
  assign o_pe_4_row = pe_q[3];
  assign o_pe_5_row = pe_q[4];

  // (a + b) mod 5 for slot indices below 5
  function automatic logic [2:0] slot_add(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
  endfunction

  // Three pixels starting at column c, leftmost pixel in the top byte
  function automatic logic [23:0] win3(input logic [ROW_BITS-1:0] r, input logic [CW-1:0] c);
    logic [ROW_BITS-1:0] s;
    s = r >> {c, 3'b000};
    return {s[7:0], s[15:8], s[23:16]};
  endfunction

  // Ring slot feeding each window row for the current pass
  always_comb begin
    rd_slot = '{default: '0};
    for (int unsigned k = 0; k < 5; k++) begin
      rd_slot[k] = slot_add(base_slot, 3'(k));
    end
  end

  // Receive / replay state machine with registered outputs and ring storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_PARAM;
      s_axis_tready  <= 1'b0;
      beat_cnt       <= '0;
      param_w0       <= '0;
      param_w1       <= '0;
      wr_word        <= '0;
      wr_slot        <= '0;
      rows_left      <= '0;
      base_slot      <= '0;
      col            <= '0;
      pass_cnt       <= '0;
      drain_cnt      <= '0;
      o_params       <= '0;
      o_params_valid <= 1'b0;
      o_pe_valid     <= 1'b0;
      o_img_row_done <= 1'b0;
      o_send_flg     <= 1'b0;
      o_err          <= 1'b0;
      for (int unsigned i = 0; i < 5; i++) begin
        ring[i] <= '0;
        pe_q[i] <= '0;
      end
    end else begin
      o_params_valid <= 1'b0;
      o_pe_valid     <= 1'b0;
      o_img_row_done <= 1'b0;
      o_send_flg     <= 1'b0;
      case (state)
        S_PARAM: begin
          s_axis_tready <= 1'b1;
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (s_axis_tlast) begin
              o_err    <= 1'b1;
              beat_cnt <= '0;
            end else if (beat_cnt == BW'(0)) begin
              param_w0 <= s_axis_tdata;
            end else if (beat_cnt == BW'(1)) begin
              param_w1 <= s_axis_tdata;
            end else begin
              o_params       <= {s_axis_tdata[15:0], param_w1, param_w0};
              o_params_valid <= 1'b1;
              pass_cnt       <= '0;
              wr_slot        <= '0;
              wr_word        <= '0;
              rows_left      <= 3'd5;
              base_slot      <= '0;
              state          <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (s_axis_tlast && beat_cnt != LAST_BEAT_V) begin
              // Premature end of frame: drop everything and resync on a new frame
              o_err    <= 1'b1;
              beat_cnt <= '0;
              state    <= S_PARAM;
            end else begin
              if (beat_cnt == LAST_BEAT_V && !s_axis_tlast) begin
                o_err <= 1'b1;
              end
              ring[wr_slot][{wr_word, 5'b00000} +: 32] <= s_axis_tdata;
              if (wr_word == LAST_WORD_V) begin
                wr_word   <= '0;
                wr_slot   <= slot_add(wr_slot, 3'd1);
                rows_left <= rows_left - 1'b1;
                if (rows_left == 3'd1) begin
                  s_axis_tready <= 1'b0;
                  col           <= '0;
                  state         <= S_EMIT;
                end
              end else begin
                wr_word <= wr_word + 1'b1;
              end
            end
          end
        end
        S_EMIT: begin
          o_pe_valid <= 1'b1;
          for (int unsigned k = 0; k < 5; k++) begin
            pe_q[k] <= win3(ring[rd_slot[k]], col);
          end
          if (col == LAST_COL_V) begin
            state <= S_DONE;
          end else begin
            col <= col + 1'b1;
          end
        end
        S_DONE: begin
          o_img_row_done <= 1'b1;
          pass_cnt       <= pass_cnt + 1'b1;
          base_slot      <= slot_add(base_slot, 3'd3);
          if (pass_cnt == LAST_PASS_V) begin
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end else begin
            rows_left     <= 3'd3;
            s_axis_tready <= 1'b1;
            state         <= S_FILL;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == LAST_DRN_V) begin
            o_send_flg    <= 1'b1;
            s_axis_tready <= 1'b1;
            beat_cnt      <= '0;
            state         <= S_PARAM;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_PARAM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_ifm_rx.sv
// Testbench for axis_ifm_rx: drives whole frames (ramp and random images,
// with and without tvalid gaps, framing errors, mid-frame reset) and checks
// every emitted window against windows computed directly from the image.
module tb_axis_ifm_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_axis_tdata = '0;
  logic [3:0]  s_axis_tkeep = 4'hF;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [79:0] o_params;
  logic        o_params_valid;
  logic [23:0] o_pe_1_row, o_pe_2_row, o_pe_3_row, o_pe_4_row, o_pe_5_row;
  logic        o_pe_valid, o_img_row_done, o_send_flg, o_err;

  axis_ifm_rx #(.IMG_W(50), .IMG_H(50), .ROW_WORDS(13), .PE_DRAIN(16)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .o_params(o_params), .o_params_valid(o_params_valid),
    .o_pe_1_row(o_pe_1_row), .o_pe_2_row(o_pe_2_row), .o_pe_3_row(o_pe_3_row),
    .o_pe_4_row(o_pe_4_row), .o_pe_5_row(o_pe_5_row),
    .o_pe_valid(o_pe_valid), .o_img_row_done(o_img_row_done),
    .o_send_flg(o_send_flg), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad = 0;
  logic [7:0]   img [50][50];
  logic [119:0] expq [$];
  int           rd_count = 0;
  int           sf_count = 0;
  longint       cyc = 0;
  longint       last_rd_cyc = 0;
  int           run = 0;
  logic         prev_v = 1'b0;
  logic         prev_pv = 1'b0;
  logic         pin_ramp = 1'b0;
  logic         timed_out = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void fill_ramp();
    for (int r = 0; r < 50; r++)
      for (int c = 0; c < 50; c++)
        img[r][c] = 8'((r * 50 + c) % 256);
  endfunction

  function automatic void fill_random();
    for (int r = 0; r < 50; r++)
      for (int c = 0; c < 50; c++)
        img[r][c] = 8'($urandom);
  endfunction

  function automatic logic [23:0] win(input int r, input int c);
    return {img[r][c], img[r][c+1], img[r][c+2]};
  endfunction

  // Pass k covers image rows 3k..3k+4, columns 0..47
  function automatic void expect_passes(input int n);
    for (int k = 0; k < n; k++)
      for (int c = 0; c < 48; c++)
        expq.push_back({win(3*k, c), win(3*k+1, c), win(3*k+2, c), win(3*k+3, c), win(3*k+4, c)});
  endfunction

  function automatic logic [31:0] beat_word(input int b, input logic [31:0] p0,
                                            input logic [31:0] p1, input logic [31:0] p2);
    logic [31:0] w;
    int r, wi, cc;
    if (b == 0) return p0;
    if (b == 1) return p1;
    if (b == 2) return p2;
    r  = (b - 3) / 13;
    wi = (b - 3) % 13;
    w  = '0;
    for (int j = 0; j < 4; j++) begin
      cc = 4 * wi + j;
      w[8*j +: 8] = (cc < 50) ? img[r][cc] : 8'($urandom);
    end
    return w;
  endfunction

  task automatic push(input logic [31:0] d, input logic last, input int gap_pct);
    logic got;
    if (timed_out) return;
    if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      s_axis_tvalid = 1'b0;
      @(posedge clk);
      #1;
    end
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 3000 && !got; n++) begin
      @(posedge clk);
      got = s_axis_tready;
    end
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!got) begin
      chk("tready_wait", got, 1'b1);
      timed_out = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                            input int gap_pct, input int tlast_beat, input int last_beat);
    for (int b = 0; b <= last_beat; b++) begin
      push(beat_word(b, p0, p1, p2), b == tlast_beat, gap_pct);
      if (b == 2 && tlast_beat != 2 && !timed_out) begin
        chk("params_valid", o_params_valid, 1'b1);
        chk("params", o_params, {p2[15:0], p1, p0});
      end
    end
  endtask

  task automatic start_frame();
    rd_count = 0;
    sf_count = 0;
    expq.delete();
  endtask

  task automatic wait_send();
    int n;
    n = 0;
    while (sf_count < 1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sf_count < 1) chk("send_wait", sf_count, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic full_frame_check(input logic exp_err);
    chk("row_done_count", rd_count, 16);
    chk("send_count", sf_count, 1);
    chk("windows_left", expq.size(), 0);
    chk("err", o_err, exp_err);
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_ctrl"}, {s_axis_tready, o_params_valid, o_pe_valid, o_img_row_done, o_send_flg, o_err}, '0);
    chk({tag, "_params"}, o_params, '0);
    chk({tag, "_pe"}, {o_pe_1_row, o_pe_2_row, o_pe_3_row, o_pe_4_row, o_pe_5_row}, '0);
  endtask

  // Per-cycle output monitor
  always @(negedge clk) begin
    logic [119:0] w;
    cyc++;
    if (rst) begin
      run     = 0;
      prev_v  = 1'b0;
      prev_pv = 1'b0;
    end else begin
      if (o_pe_valid) begin
        chk("tready_in_emit", s_axis_tready, 1'b0);
        if (expq.size() == 0) begin
          chk("extra_window", expq.size(), 1);
        end else begin
          w = expq.pop_front();
          chk("window", {o_pe_1_row, o_pe_2_row, o_pe_3_row, o_pe_4_row, o_pe_5_row}, w);
        end
        if (pin_ramp && run == 0 && rd_count == 0) begin
          chk("ramp_p0_row1", o_pe_1_row, 24'h000102);
          chk("ramp_p0_row5", o_pe_5_row, 24'hC8C9CA);
        end
        if (pin_ramp && run == 0 && rd_count == 1)
          chk("ramp_p1_row1", o_pe_1_row, 24'h969798);
        run++;
      end else begin
        if (prev_v) begin
          chk("valid_run_len", run, 48);
          chk("row_done_after_valid", o_img_row_done, 1'b1);
        end else if (o_img_row_done) begin
          chk("row_done_spurious", prev_v, 1'b1);
        end
        run = 0;
      end
      if (o_img_row_done) begin
        rd_count++;
        if (rd_count == 16) last_rd_cyc = cyc;
      end
      if (o_send_flg) begin
        sf_count++;
        if (rd_count == 16) chk("send_delay", cyc - last_rd_cyc, 16);
        else chk("send_without_16_passes", rd_count, 16);
      end
      if (o_params_valid) chk("params_valid_width", prev_pv, 1'b0);
      prev_v  = o_pe_valid;
      prev_pv = o_params_valid;
    end
  end

  initial begin
    logic [31:0] r0, r1, r2;
    int n;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    zero_check("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("tready_after_reset", s_axis_tready, 1'b1);

    // A: ramp image, literal params, no gaps
    fill_ramp();
    pin_ramp = 1'b1;
    start_frame();
    expect_passes(16);
    send_frame(32'h03020100, 32'h07060504, 32'h0000AB08, 0, 652, 652);
    wait_send();
    full_frame_check(1'b0);
    chk("params_literal", o_params, 80'hAB08_07060504_03020100);

    // B: random image and params, 50% tvalid gaps
    fill_random();
    pin_ramp = 1'b0;
    start_frame();
    expect_passes(16);
    r0 = $urandom; r1 = $urandom; r2 = $urandom;
    send_frame(r0, r1, r2, 50, 652, 652);
    wait_send();
    full_frame_check(1'b0);

    // C: premature tlast on beat 100 (pass 0 already replayed by then)
    fill_ramp();
    pin_ramp = 1'b1;
    start_frame();
    expect_passes(1);
    send_frame(32'h11111111, 32'h22222222, 32'h33333333, 0, 100, 100);
    repeat (40) @(negedge clk);
    chk("tlast_err", o_err, 1'b1);
    chk("tlast_err_passes", rd_count, 1);
    chk("tlast_err_no_send", sf_count, 0);
    chk("tlast_err_windows_left", expq.size(), 0);
    chk("tlast_err_tready", s_axis_tready, 1'b1);

    // D: good ramp frame after the error, with some gaps
    start_frame();
    expect_passes(16);
    send_frame(32'h03020100, 32'h07060504, 32'h0000AB08, 25, 652, 652);
    wait_send();
    full_frame_check(1'b1);

    // E: reset during pass 5 replay
    start_frame();
    expect_passes(16);
    send_frame(32'h03020100, 32'h07060504, 32'h0000AB08, 0, 652, 262);
    n = 0;
    while (!(rd_count == 5 && o_pe_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_pass5", rd_count, 5);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    zero_check("mid_reset");
    expq.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("tready_after_mid_reset", s_axis_tready, 1'b1);

    // F: full ramp frame after reset, error flag cleared
    start_frame();
    expect_passes(16);
    send_frame(32'h03020100, 32'h07060504, 32'h0000AB08, 0, 652, 652);
    wait_send();
    full_frame_check(1'b0);

    // G: missing tlast on the final beat flags an error but replays normally
    fill_random();
    pin_ramp = 1'b0;
    start_frame();
    expect_passes(16);
    r0 = $urandom; r1 = $urandom; r2 = $urandom;
    send_frame(r0, r1, r2, 30, -1, 652);
    wait_send();
    full_frame_check(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
